// File: rtl/ws_accel_pkg.sv
// Shared types and helpers for the weight-stationary convolution sequencer.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package ws_accel_pkg;

   // Sequencer states, in the order a channel normally walks through them.
   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_CHECK   = 3'd1,
      ST_LOAD_W  = 3'd2,
      ST_WAIT_W  = 3'd3,
      ST_FEED    = 3'd4,
      ST_DRAIN   = 3'd5,
      ST_NEXT_CH = 3'd6,
      ST_FIN     = 3'd7
   } state_e;

   // The channel count and the per-channel length are stored at a fixed
   // maximum width. The struct then does not depend on the instance's
   // CH_W/LEN_W. Unused upper bits are tied to zero and trimmed by synthesis.
   localparam int CFG_C_MAX_W   = 32;
   localparam int CFG_LEN_MAX_W = 32;

   typedef struct packed {
      logic [3:0]               r;
      logic [3:0]               s;
      logic [3:0]               tile;
      logic [CFG_C_MAX_W-1:0]   c;
      logic [CFG_LEN_MAX_W-1:0] in_len;
      logic                     psum_en;
   } cfg_t;

   // Cycles from an accepted activation to its result leaving the array.
   // The horizontal pass takes pe_cols*pipe_depth cycles.
   // The vertical reduction then adds one cycle per row.
   function automatic int lat_f(input int pe_rows, input int pe_cols, input int pipe_depth);
      return pe_cols * pipe_depth + pe_rows;
   endfunction

   // A config is usable only if the filter fits the array.
   // The tile must be within the supported range.
   // Both loop counts must be non-zero.
   function automatic logic cfg_legal(input cfg_t cfg, input int pe_rows,
                                      input int pe_cols, input int max_tile);
      logic bad;
      bad = (cfg.r == 4'd0) || (int'(cfg.r) > pe_rows) ||
            (cfg.s == 4'd0) || (int'(cfg.s) > pe_cols) ||
            (cfg.tile == 4'd0) || (int'(cfg.tile) > max_tile) ||
            (cfg.c == '0) || (cfg.in_len == '0);
      return !bad;
   endfunction

endpackage

// File: rtl/ws_lat_tracker.sv
// Valid-bit shadow of the MAC pipeline; a 1 entering emerges at tail after DEPTH enabled cycles.
// Latency: exactly DEPTH cycles with shift_en high; frozen cycles add no age.
// Backpressure: shift_en low freezes every stage, so a stalled array and its shadow stay aligned.
module ws_lat_tracker #(
   parameter int DEPTH = 15
) (
   input  logic clk,
   input  logic reset,
   input  logic shift_en,
   input  logic din,
   output logic tail,
   output logic empty
);

   logic [DEPTH-1:0] sr_d;
   logic [DEPTH-1:0] sr_q;

   // Shift one stage per enabled cycle; hold everything while stalled.
   always_comb begin
      sr_d = sr_q;
      if (shift_en) begin
         sr_d = {sr_q[DEPTH-2:0], din};
      end
   end

   // Pipeline occupancy register.
   always_ff @(posedge clk) begin
      if (reset) begin
         sr_q <= '0;
      end else begin
         sr_q <= sr_d;
      end
   end

   assign tail  = sr_q[DEPTH-1];
   assign empty = (sr_q == '0);

endmodule

// File: rtl/ws_conv_sequencer.sv
// Sequences a multi-channel convolution tile on a weight-stationary PE array.
// Latency: result strobe follows each accepted activation by LAT unstalled cycles.
// Backpressure: OUT_FULL stalls the array and pipeline; PSUM_EMPTY holds IN_RDY low when accumulating.
module ws_conv_sequencer
   import ws_accel_pkg::*;
#(
   parameter int PE_ROWS        = 5,
   parameter int PE_COLS        = 5,
   parameter int MAC_PIPE_DEPTH = 2,
   parameter int MAX_TILE       = 9,
   parameter int CH_W           = 12,
   parameter int LEN_W          = 16,
   localparam int PSUM_SEL_W    = (PE_ROWS > 1) ? $clog2(PE_ROWS) : 1
) (
   input  logic                         CLK,
   input  logic                         RESET,
   input  logic                         START,
   input  logic [3:0]                   CFG_R,
   input  logic [3:0]                   CFG_S,
   input  logic [3:0]                   CFG_TILE,
   input  logic [CH_W-1:0]              CFG_C,
   input  logic [LEN_W-1:0]             CFG_IN_LEN,
   input  logic                         CFG_PSUM_EN,
   output logic                         W_LOAD_REQ,
   input  logic                         W_READY,
   input  logic                         IN_VALID,
   output logic                         IN_RDY,
   output logic                         PSUM_RD,
   output logic                         PSUM_WR,
   output logic                         OUT_WR,
   input  logic                         OUT_FULL,
   input  logic                         PSUM_EMPTY,
   output logic [PE_ROWS*PE_COLS-1:0]   ADD_MUX_CTRL,
   output logic [PE_ROWS*PE_COLS-1:0]   STALL_CTRL,
   output logic [PE_ROWS*4-1:0]         ROW_OUT_MUX_CTRL,
   output logic [PSUM_SEL_W-1:0]        PSUM_OUT_MUX_CTRL,
   output logic [CH_W-1:0]              CUR_CH,
   output logic                         BUSY,
   output logic                         DONE,
   output logic                         ERR
);

   localparam int LAT = lat_f(PE_ROWS, PE_COLS, MAC_PIPE_DEPTH);

   state_e                       state_d;
   state_e                       state_q;
   cfg_t                         cfg_d;
   cfg_t                         cfg_q;
   logic [LEN_W-1:0]             in_cnt_d;
   logic [LEN_W-1:0]             in_cnt_q;
   logic [CH_W-1:0]              cur_ch_d;
   logic [CH_W-1:0]              cur_ch_q;
   logic [PE_ROWS*PE_COLS-1:0]   add_mux_d;
   logic [PE_ROWS*PE_COLS-1:0]   add_mux_q;
   logic [PE_ROWS*4-1:0]         row_mux_d;
   logic [PE_ROWS*4-1:0]         row_mux_q;
   logic [PSUM_SEL_W-1:0]        psum_sel_d;
   logic [PSUM_SEL_W-1:0]        psum_sel_q;

   logic                         cfg_ok;
   logic                         acc_psum;
   logic                         last_ch;
   logic                         accept;
   logic                         in_rdy;
   logic                         wr_stb;
   logic                         lat_tail;
   logic                         lat_empty;
   logic [CFG_LEN_MAX_W-1:0]     in_cnt_nxt;

   // Datapath qualifiers for the channel in progress.
   // Every strobe is gated by RESET so an abort issues no FIFO traffic in its own cycle.
   always_comb begin
      cfg_ok     = cfg_legal(cfg_q, PE_ROWS, PE_COLS, MAX_TILE);
      acc_psum   = (cur_ch_q != '0) || cfg_q.psum_en;
      last_ch    = (CFG_C_MAX_W'(cur_ch_q) == (cfg_q.c - CFG_C_MAX_W'(1)));
      in_rdy     = !RESET && (state_q == ST_FEED) && !OUT_FULL && !(acc_psum && PSUM_EMPTY);
      accept     = IN_VALID && in_rdy;
      in_cnt_nxt = CFG_LEN_MAX_W'(in_cnt_q) + CFG_LEN_MAX_W'(1);
      wr_stb     = lat_tail && !OUT_FULL && !RESET;
   end

   // Valid shadow of the MAC pipeline. It freezes together with the array on OUT_FULL.
   ws_lat_tracker #(
      .DEPTH (LAT)
   ) u_lat (
      .clk      (CLK),
      .reset    (RESET),
      .shift_en (!OUT_FULL),
      .din      (accept),
      .tail     (lat_tail),
      .empty    (lat_empty)
   );

   // Next-state logic, config capture, channel/beat counters and mux-map generation.
   always_comb begin
      state_d    = state_q;
      cfg_d      = cfg_q;
      in_cnt_d   = in_cnt_q;
      cur_ch_d   = cur_ch_q;
      add_mux_d  = add_mux_q;
      row_mux_d  = row_mux_q;
      psum_sel_d = psum_sel_q;
      W_LOAD_REQ = 1'b0;
      DONE       = 1'b0;
      ERR        = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (START) begin
               cfg_d.r       = CFG_R;
               cfg_d.s       = CFG_S;
               cfg_d.tile    = CFG_TILE;
               cfg_d.c       = CFG_C_MAX_W'(CFG_C);
               cfg_d.in_len  = CFG_LEN_MAX_W'(CFG_IN_LEN);
               cfg_d.psum_en = CFG_PSUM_EN;
               cur_ch_d      = '0;
               in_cnt_d      = '0;
               state_d       = ST_CHECK;
            end
         end

         ST_CHECK: begin
            if (!cfg_ok) begin
               ERR     = 1'b1;
               state_d = ST_IDLE;
            end else begin
               // Enable only the adders covered by the R x S filter footprint.
               for (int r = 0; r < PE_ROWS; r++) begin
                  for (int c = 0; c < PE_COLS; c++) begin
                     add_mux_d[r*PE_COLS + c] = (r < int'(cfg_q.r)) && (c < int'(cfg_q.s));
                  end
                  row_mux_d[r*4 +: 4] = cfg_q.tile - 4'd1;
               end
               psum_sel_d = PSUM_SEL_W'(cfg_q.r - 4'd1);
               state_d    = ST_LOAD_W;
            end
         end

         ST_LOAD_W: begin
            W_LOAD_REQ = 1'b1;
            state_d    = ST_WAIT_W;
         end

         ST_WAIT_W: begin
            if (W_READY) begin
               state_d = ST_FEED;
            end
         end

         ST_FEED: begin
            if (accept) begin
               in_cnt_d = in_cnt_q + LEN_W'(1);
               if (in_cnt_nxt == cfg_q.in_len) begin
                  state_d = ST_DRAIN;
               end
            end
         end

         ST_DRAIN: begin
            if (lat_empty) begin
               state_d = ST_NEXT_CH;
            end
         end

         ST_NEXT_CH: begin
            if (last_ch) begin
               state_d = ST_FIN;
            end else begin
               cur_ch_d = cur_ch_q + CH_W'(1);
               in_cnt_d = '0;
               state_d  = ST_LOAD_W;
            end
         end

         ST_FIN: begin
            DONE    = 1'b1;
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (RESET) begin
         W_LOAD_REQ = 1'b0;
         DONE       = 1'b0;
         ERR        = 1'b0;
      end
   end

   // State, config and counter registers; reset aborts any run in progress.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q    <= ST_IDLE;
         cfg_q      <= '0;
         in_cnt_q   <= '0;
         cur_ch_q   <= '0;
         add_mux_q  <= '0;
         row_mux_q  <= '0;
         psum_sel_q <= '0;
      end else begin
         state_q    <= state_d;
         cfg_q      <= cfg_d;
         in_cnt_q   <= in_cnt_d;
         cur_ch_q   <= cur_ch_d;
         add_mux_q  <= add_mux_d;
         row_mux_q  <= row_mux_d;
         psum_sel_q <= psum_sel_d;
      end
   end

   // Output strobes and array controls.
   // The array runs only while data moves through it (FEED/DRAIN) and the output FIFO has room.
   always_comb begin
      IN_RDY            = in_rdy;
      PSUM_RD           = accept && acc_psum;
      OUT_WR            = wr_stb && last_ch;
      PSUM_WR           = wr_stb && !last_ch;
      STALL_CTRL        = (OUT_FULL || !((state_q == ST_FEED) || (state_q == ST_DRAIN))) ? '1 : '0;
      ADD_MUX_CTRL      = add_mux_q;
      ROW_OUT_MUX_CTRL  = row_mux_q;
      PSUM_OUT_MUX_CTRL = psum_sel_q;
      CUR_CH            = cur_ch_q;
      BUSY              = (state_q != ST_IDLE);
   end

endmodule

// File: tb/tb_ws_conv_sequencer.sv
// Scoreboard bench for ws_conv_sequencer with directed runs.
// Each accepted beat queues its expected strobe (target FIFO, unstalled-cycle time).
// A negedge monitor pops the queue on every write strobe and checks per-run totals on DONE/ERR.
module tb_ws_conv_sequencer;

   localparam int PE_ROWS = 5;
   localparam int PE_COLS = 5;
   localparam int CH_W    = 12;
   localparam int LEN_W   = 16;
   localparam int LAT     = 15;   // 5 cols * 2 pipe stages + 5 rows

   logic                 CLK = 1'b0;
   logic                 RESET;
   logic                 START;
   logic [3:0]           CFG_R;
   logic [3:0]           CFG_S;
   logic [3:0]           CFG_TILE;
   logic [CH_W-1:0]      CFG_C;
   logic [LEN_W-1:0]     CFG_IN_LEN;
   logic                 CFG_PSUM_EN;
   logic                 W_LOAD_REQ;
   logic                 W_READY;
   logic                 IN_VALID;
   logic                 IN_RDY;
   logic                 PSUM_RD;
   logic                 PSUM_WR;
   logic                 OUT_WR;
   logic                 OUT_FULL;
   logic                 PSUM_EMPTY;
   logic [24:0]          ADD_MUX_CTRL;
   logic [24:0]          STALL_CTRL;
   logic [19:0]          ROW_OUT_MUX_CTRL;
   logic [2:0]           PSUM_OUT_MUX_CTRL;
   logic [CH_W-1:0]      CUR_CH;
   logic                 BUSY;
   logic                 DONE;
   logic                 ERR;

   always #5 CLK = ~CLK;

   ws_conv_sequencer #(
      .PE_ROWS(PE_ROWS), .PE_COLS(PE_COLS), .MAC_PIPE_DEPTH(2),
      .MAX_TILE(9), .CH_W(CH_W), .LEN_W(LEN_W)
   ) dut (
      .CLK(CLK), .RESET(RESET), .START(START),
      .CFG_R(CFG_R), .CFG_S(CFG_S), .CFG_TILE(CFG_TILE), .CFG_C(CFG_C),
      .CFG_IN_LEN(CFG_IN_LEN), .CFG_PSUM_EN(CFG_PSUM_EN),
      .W_LOAD_REQ(W_LOAD_REQ), .W_READY(W_READY),
      .IN_VALID(IN_VALID), .IN_RDY(IN_RDY),
      .PSUM_RD(PSUM_RD), .PSUM_WR(PSUM_WR), .OUT_WR(OUT_WR),
      .OUT_FULL(OUT_FULL), .PSUM_EMPTY(PSUM_EMPTY),
      .ADD_MUX_CTRL(ADD_MUX_CTRL), .STALL_CTRL(STALL_CTRL),
      .ROW_OUT_MUX_CTRL(ROW_OUT_MUX_CTRL), .PSUM_OUT_MUX_CTRL(PSUM_OUT_MUX_CTRL),
      .CUR_CH(CUR_CH), .BUSY(BUSY), .DONE(DONE), .ERR(ERR)
   );

   // Expectations written by the stimulus process, read by the monitor.
   int          tb_len;
   int          tb_c;
   bit          tb_psum;
   logic [24:0] exp_add;
   logic [19:0] exp_row;
   logic [2:0]  exp_psel;
   bit          exp_err;
   int          exp_wl;
   int          exp_out;
   int          exp_pw;
   int          exp_pr;
   int          exp_lat;
   int          tmo_req;
   bit          end_req;

   // Scoreboard and monitor state (monitor process only).
   typedef struct {
      int when;
      bit is_out;
   } exp_t;
   exp_t exp_q[$];

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int u_cnt    = 0;
   int acc_cnt  = 0;
   int start_cyc = 0;
   int run_wl = 0, run_out = 0, run_pw = 0, run_pr = 0, run_busy = 0;
   int tmo_seen = 0;
   bit after_rst = 0;
   bit after_err = 0;
   bit end_done  = 0;

   task automatic chk(input string name, input longint act, input longint req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   always @(negedge CLK) begin
      exp_t e;
      int   ch;
      bit   ch_acc;
      if (RESET) begin
         chk("strobes_during_reset",
             longint'({W_LOAD_REQ, IN_RDY, PSUM_RD, PSUM_WR, OUT_WR, DONE, ERR}), 0);
         exp_q.delete();
         acc_cnt   = 0;
         after_rst = 1;
      end else begin
         if (after_rst) begin
            chk("rst_busy", longint'(BUSY), 0);
            chk("rst_cur_ch", longint'(CUR_CH), 0);
            chk("rst_stall_ctrl", longint'(STALL_CTRL), longint'(25'h1FFFFFF));
            chk("rst_add_mux", longint'(ADD_MUX_CTRL), 0);
            chk("rst_row_mux", longint'(ROW_OUT_MUX_CTRL), 0);
            chk("rst_psum_sel", longint'(PSUM_OUT_MUX_CTRL), 0);
            chk("rst_strobes", longint'({W_LOAD_REQ, PSUM_RD, PSUM_WR, OUT_WR, DONE, ERR}), 0);
            after_rst = 0;
         end
         if (START && !BUSY) begin
            start_cyc = cyc;
            acc_cnt = 0; run_wl = 0; run_out = 0; run_pw = 0; run_pr = 0; run_busy = 0;
         end
         if (BUSY) run_busy++;
         if (after_err) begin
            chk("idle_after_err", longint'(BUSY), 0);
            after_err = 0;
         end
         ch     = (tb_len > 0) ? acc_cnt / tb_len : 0;
         ch_acc = tb_psum || (ch > 0);
         if (W_LOAD_REQ) begin
            chk("cur_ch_at_load", longint'(CUR_CH), longint'(run_wl));
            chk("add_mux_map", longint'(ADD_MUX_CTRL), longint'(exp_add));
            chk("row_out_mux", longint'(ROW_OUT_MUX_CTRL), longint'(exp_row));
            chk("psum_out_mux", longint'(PSUM_OUT_MUX_CTRL), longint'(exp_psel));
            run_wl++;
         end
         if (OUT_FULL) begin
            chk("stall_ctrl_when_full", longint'(STALL_CTRL), longint'(25'h1FFFFFF));
            chk("no_rdy_when_full", longint'(IN_RDY), 0);
            chk("no_wr_when_full", longint'({OUT_WR, PSUM_WR}), 0);
         end
         if (PSUM_EMPTY && ch_acc) chk("no_rdy_psum_empty", longint'(IN_RDY), 0);
         chk("psum_rd_with_accept", longint'(PSUM_RD), longint'(IN_VALID && IN_RDY && ch_acc));
         if (PSUM_RD) run_pr++;
         if (IN_VALID && IN_RDY) begin
            e.when   = u_cnt + LAT;
            e.is_out = (ch == tb_c - 1);
            exp_q.push_back(e);
            acc_cnt++;
         end
         if (OUT_WR || PSUM_WR) begin
            chk("wr_exclusive", longint'(OUT_WR && PSUM_WR), 0);
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_write out_wr=%0d psum_wr=%0d with no accepted beat pending",
                        OUT_WR, PSUM_WR);
            end else begin
               e = exp_q.pop_front();
               chk("wr_latency", longint'(u_cnt), longint'(e.when));
               chk("wr_target_out", longint'(OUT_WR), longint'(e.is_out));
            end
         end
         if (OUT_WR) run_out++;
         if (PSUM_WR) run_pw++;
         if (DONE) begin
            chk("done_expected", longint'(DONE), longint'(!exp_err));
            chk("done_latency", longint'(cyc - start_cyc), longint'(exp_lat));
            chk("w_load_count", longint'(run_wl), longint'(exp_wl));
            chk("out_wr_count", longint'(run_out), longint'(exp_out));
            chk("psum_wr_count", longint'(run_pw), longint'(exp_pw));
            chk("psum_rd_count", longint'(run_pr), longint'(exp_pr));
            chk("queue_empty_at_done", longint'(exp_q.size()), 0);
         end
         if (ERR) begin
            chk("err_expected", longint'(ERR), longint'(exp_err));
            chk("err_no_w_load", longint'(run_wl), 0);
            chk("err_busy_cycles", longint'(run_busy), 1);
            after_err = 1;
         end
         if (!OUT_FULL) u_cnt++;
      end
      if (tmo_req != tmo_seen) begin
         checks++;
         failures++;
         $display("FAIL run_timeout no DONE or ERR within budget (busy=%0d)", BUSY);
         tmo_seen = tmo_req;
      end
      if (end_req && !end_done) begin
         chk("queue_empty_at_end", longint'(exp_q.size()), 0);
         end_done = 1;
      end
      cyc++;
   end

   task automatic set_cfg(input int r, input int s, input int tile, input int c,
                          input int len, input bit pen);
      CFG_R = 4'(r); CFG_S = 4'(s); CFG_TILE = 4'(tile);
      CFG_C = CH_W'(c); CFG_IN_LEN = LEN_W'(len); CFG_PSUM_EN = pen;
      tb_c = c; tb_len = len; tb_psum = pen;
   endtask

   task automatic set_exp(input logic [24:0] add, input logic [19:0] row, input logic [2:0] psel,
                          input bit err, input int wl, input int outw, input int pw,
                          input int pr, input int lat);
      exp_add = add; exp_row = row; exp_psel = psel; exp_err = err;
      exp_wl = wl; exp_out = outw; exp_pw = pw; exp_pr = pr; exp_lat = lat;
   endtask

   // Called just after a posedge: START is high for exactly one cycle.
   task automatic pulse_start();
      START = 1'b1;
      @(posedge CLK); #1;
      START = 1'b0;
   endtask

   task automatic wait_end(input int budget);
      bit seen = 0;
      for (int i = 0; i < budget; i++) begin
         @(negedge CLK);
         if (DONE || ERR) begin
            seen = 1;
            break;
         end
      end
      if (!seen) begin
         tmo_req++;
         @(posedge CLK); #1 RESET = 1'b1;
         @(posedge CLK); #1 RESET = 1'b0;
      end
      repeat (2) @(posedge CLK);
      #1;
   endtask

   initial begin
      RESET = 1'b1; START = 1'b0; W_READY = 1'b1; IN_VALID = 1'b1;
      OUT_FULL = 1'b0; PSUM_EMPTY = 1'b0;
      tmo_req = 0; end_req = 0;
      set_cfg(0, 0, 0, 0, 0, 0);
      tb_len = 1; tb_c = 1;
      set_exp('0, '0, '0, 0, 0, 0, 0, 0, 0);
      repeat (3) @(posedge CLK);
      #1 RESET = 1'b0;
      repeat (2) @(posedge CLK);
      #1;

      // 1: single channel, weight store slow by 3 cycles.
      W_READY = 1'b0;
      set_cfg(3, 3, 5, 1, 10, 0);
      set_exp(25'h1CE7, 20'h44444, 3'd2, 0, 1, 10, 0, 0, 34);
      pulse_start();
      repeat (5) @(posedge CLK);
      #1 W_READY = 1'b1;
      wait_end(200);

      // 2: three channels, four beats each.
      set_cfg(3, 3, 5, 3, 4, 0);
      set_exp(25'h1CE7, 20'h44444, 3'd2, 0, 3, 4, 8, 8, 71);
      pulse_start();
      wait_end(400);

      // 3: illegal configs (R too big, then TILE zero).
      set_cfg(6, 3, 5, 1, 4, 0);
      set_exp(25'h1CE7, 20'h44444, 3'd2, 1, 0, 0, 0, 0, 0);
      pulse_start();
      wait_end(20);
      set_cfg(3, 3, 0, 1, 4, 0);
      pulse_start();
      wait_end(20);

      // 4: as run 2. A stray START and config change mid-run must be ignored.
      // OUT_FULL is then held for 7 cycles during the last channel's drain.
      set_cfg(3, 3, 5, 3, 4, 0);
      set_exp(25'h1CE7, 20'h44444, 3'd2, 0, 3, 4, 8, 8, 78);
      pulse_start();
      repeat (19) @(posedge CLK);
      #1 START = 1'b1; CFG_C = CH_W'(1); CFG_R = 4'd1;
      @(posedge CLK);
      #1 START = 1'b0;
      repeat (42) @(posedge CLK);
      #1 OUT_FULL = 1'b1;
      repeat (7) @(posedge CLK);
      #1 OUT_FULL = 1'b0;
      wait_end(400);

      // 5: external psum accumulation; psum FIFO empty for the first 5 feed cycles.
      set_cfg(5, 5, 1, 1, 10, 1);
      set_exp(25'h1FFFFFF, 20'h00000, 3'd4, 0, 1, 10, 0, 10, 36);
      pulse_start();
      repeat (3) @(posedge CLK);
      #1 PSUM_EMPTY = 1'b1;
      repeat (5) @(posedge CLK);
      #1 PSUM_EMPTY = 1'b0;
      wait_end(200);

      // 6: reset during channel 1 feed, then a clean restart.
      set_cfg(3, 3, 5, 3, 4, 0);
      set_exp(25'h1CE7, 20'h44444, 3'd2, 0, 3, 4, 8, 8, 71);
      pulse_start();
      repeat (27) @(posedge CLK);
      #1 RESET = 1'b1;
      @(posedge CLK);
      #1 RESET = 1'b0;
      repeat (3) @(posedge CLK);
      #1;
      set_cfg(2, 4, 9, 1, 4, 0);
      set_exp(25'h1EF, 20'h88888, 3'd1, 0, 1, 4, 0, 0, 25);
      pulse_start();
      wait_end(200);

      end_req = 1'b1;
      repeat (3) @(negedge CLK);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ws_conv_sequencer.md
Name: ws_conv_sequencer

Overview:
- Parametrised successor to the fixed 5x5 accelerator control unit. Sequences a full multi-channel convolution tile on a weight-stationary PE array of arbitrary size.
- For each channel in turn it:
  - requests a weight-store load;
  - streams activations with back-pressure;
  - routes psums to the feedback FIFO or the output FIFO;
  - drains the MAC pipeline.
- Sits between the AXI-lite register file and the PE array, weight_in_ctrl, input_act_ctrl, psum FIFO and output FIFO.

Parameters:
- PE_ROWS, 5, MAC rows in array.
- PE_COLS, 5, MAC columns in array.
- MAC_PIPE_DEPTH, 2, pipeline stages per MAC.
- MAX_TILE, 9, largest legal tile size.
- CH_W, 12, channel-count width.
- LEN_W, 16, per-channel input-count width.

Ports:
- CLK  in  1  clock
- RESET  in  1  synchronous active-high reset
- START  in  1  pulse; latches config and begins
- CFG_R  in  4  filter height
- CFG_S  in  4  filter width
- CFG_TILE  in  4  tile size
- CFG_C  in  CH_W  input channels
- CFG_IN_LEN  in  LEN_W  activations per channel
- CFG_PSUM_EN  in  1  1 = channel 0 also accumulates external psums
- W_LOAD_REQ  out  1  pulse to weight_in_ctrl
- W_READY  in  1  weight store loaded
- IN_VALID  in  1  activation available
- IN_RDY  out  1  activation accepted when IN_VALID&IN_RDY
- PSUM_RD  out  1  pop psum FIFO
- PSUM_WR  out  1  push psum feedback
- OUT_WR  out  1  push output FIFO
- OUT_FULL  in  1  output FIFO full
- PSUM_EMPTY  in  1  psum FIFO empty
- ADD_MUX_CTRL  out  PE_ROWS x PE_COLS  adder enable map
- STALL_CTRL  out  PE_ROWS x PE_COLS  array stall
- ROW_OUT_MUX_CTRL  out  PE_ROWS x 4  per-row output tap
- PSUM_OUT_MUX_CTRL  out  clog2(PE_ROWS)  final-row select
- CUR_CH  out  CH_W  channel in progress
- BUSY  out  1  not IDLE
- DONE  out  1  one-cycle pulse on completion
- ERR  out  1  one-cycle pulse on illegal config

Behaviour:
- Reset values:
  - all outputs 0, except STALL_CTRL = all ones;
  - FSM in IDLE; counters cleared.
  - RESET mid-operation aborts immediately; no further FIFO strobes are issued.
- States: IDLE, CHECK, LOAD_W, WAIT_W, FEED, DRAIN, NEXT_CH, FIN.
- IDLE:
  - START=1 registers all CFG_* values.
  - Go to CHECK. START in any other state is ignored.
- CHECK (1 cycle):
  - Config is illegal if any of: R=0, R>PE_ROWS, S=0, S>PE_COLS, TILE=0, TILE>MAX_TILE, C=0, IN_LEN=0.
  - Illegal: ERR=1 for one cycle, return to IDLE.
  - Legal: drive mux controls and go to LOAD_W.
  - Mux controls:
    - ADD_MUX_CTRL[r][c] = (r<R && c<S);
    - ROW_OUT_MUX_CTRL[r] = TILE-1;
    - PSUM_OUT_MUX_CTRL = R-1.
  - These values are held until the next CHECK.
- LOAD_W: W_LOAD_REQ=1 for exactly one cycle, then go to WAIT_W.
- WAIT_W: wait for W_READY=1, then go to FEED.
- FEED:
  - IN_RDY = !OUT_FULL && !(acc_psum && PSUM_EMPTY), where acc_psum = (CUR_CH>0) || CFG_PSUM_EN.
  - Each accepted beat increments in_cnt and pushes a 1 into the latency shift register of length LAT = PE_COLS*MAC_PIPE_DEPTH + PE_ROWS.
  - PSUM_RD equals the accept strobe when acc_psum=1.
  - When in_cnt reaches CFG_IN_LEN, go to DRAIN.
  - Cycles with no accept push a 0.
- Stall:
  - Applies while OUT_FULL=1 (any state).
  - STALL_CTRL = all ones, the shift register freezes, no write strobes are issued.
  - Otherwise STALL_CTRL = 0 in FEED/DRAIN and all ones elsewhere.
- Shift-register output:
  - Tail=1 and not stalled gives a write strobe: OUT_WR if CUR_CH = C-1, else PSUM_WR.
  - The two strobes are never asserted together.
  - Latency from accept to strobe is exactly LAT unstalled cycles.
- DRAIN: wait until the shift register is all zero, then go to NEXT_CH.
- NEXT_CH:
  - If CUR_CH = C-1, go to FIN.
  - Otherwise CUR_CH++, clear in_cnt, go to LOAD_W.
- FIN: DONE=1 for one cycle, go to IDLE.
- BUSY = (state != IDLE).
- Widths and arithmetic:
  - Counters are unsigned with no wrap: in_cnt is LEN_W wide, CUR_CH is CH_W wide.
  - Maximum C = 2^CH_W - 1.

Decomposition:
- Package ws_accel_pkg holds:
  - the state enum;
  - the LAT function of the parameters;
  - the config struct (R, S, TILE, C, IN_LEN, PSUM_EN);
  - the legality function.
- One sub-module: ws_lat_tracker, the freezable LAT-deep valid shift register with an empty flag.

Test Plan:
1. Legal single channel, no psum: R=3, S=3, TILE=5, C=1, IN_LEN=10, IN_VALID held 1.
   - One W_LOAD_REQ; ten accepts; ten OUT_WR, the first exactly LAT=15 cycles after the first accept.
   - PSUM_RD=0 and PSUM_WR=0 throughout; DONE pulse.
2. C=3, IN_LEN=4.
   - Three W_LOAD_REQ pulses; PSUM_WR=8; PSUM_RD=8 (channels 1–2); OUT_WR=4.
   - CUR_CH sequence 0,1,2; ADD_MUX_CTRL rows 0–2, cols 0–2 = 1, others 0.
3. Illegal configs R=6, then TILE=0 (PE_ROWS=5).
   - ERR pulse each time; no W_LOAD_REQ; BUSY high only during CHECK.
4. OUT_FULL asserted for 7 cycles mid-drain on the last channel.
   - STALL_CTRL all ones; no OUT_WR and no accepts during the stall.
   - Total OUT_WR count unchanged; completion delayed exactly 7 cycles.
5. CFG_PSUM_EN=1, C=1, PSUM_EMPTY=1 for 5 cycles.
   - IN_RDY=0 during those cycles; afterwards each accept has a coincident PSUM_RD.
6. RESET asserted during FEED of channel 1.
   - Next cycle: IDLE, CUR_CH=0, no strobes.
   - A new START runs cleanly from channel 0.
